// File: rtl/shift_pipe_n.sv
// Purpose: DEPTH x WIDTH shift pipeline. It supports forward/backward shift, rotate, parallel load, clear, a tap port and a fill counter.
// Latency: one cycle from sin_f/sin_b/pdata to the stage; DEPTH forward-shift edges from sin_f to sout_f.
// Backpressure: none. The pipe moves only when mode requests it, and mode 00 stalls it without losing data.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   clr               synchronous clear (wins over mode)
//   mode, rot         00 hold, 01 forward, 10 backward, 11 load; rot turns a shift into a rotate
//   sin_f, sin_b      serial inputs into stage 0 (forward) / stage DEPTH-1 (backward)
//   pdata, pout       all stages packed, stage i at [i*WIDTH +: WIDTH]
//   sout_f, sout_b    stage DEPTH-1 / stage 0
//   tap_sel, tap      stage select and its value (0 when tap_sel >= DEPTH)
//   fill, full        count of written stages (saturates at DEPTH), fill == DEPTH
module shift_pipe_n #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [1:0]               mode,
    input  logic                     rot,
    input  logic [WIDTH-1:0]         sin_f,
    input  logic [WIDTH-1:0]         sin_b,
    input  logic [DEPTH*WIDTH-1:0]   pdata,
    input  logic [CW-1:0]            tap_sel,
    output logic [DEPTH*WIDTH-1:0]   pout,
    output logic [WIDTH-1:0]         sout_f,
    output logic [WIDTH-1:0]         sout_b,
    output logic [WIDTH-1:0]         tap,
    output logic [CW-1:0]            fill,
    output logic                     full
);

    logic [WIDTH-1:0] q     [DEPTH];
    logic [WIDTH-1:0] q_nxt [DEPTH];
    logic [CW-1:0]    fill_nxt;

    assign full   = (fill == CW'(DEPTH));
    assign sout_f = q[DEPTH-1];
    assign sout_b = q[0];

    // The next state is built entirely from pre-edge q. As a result, every
    // stage moves together and no value cascades through several stages in one cycle.
    always_comb begin
        q_nxt    = q;
        fill_nxt = fill;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) q_nxt[i] = '0;
            fill_nxt = '0;
        end else begin
            case (mode)
                2'b01: begin
                    q_nxt[0] = rot ? q[DEPTH-1] : sin_f;
                    for (int i = 1; i < DEPTH; i++) q_nxt[i] = q[i-1];
                    // A rotate writes no new data, so only a serial shift counts.
                    if (!rot && !full) fill_nxt = fill + CW'(1);
                end
                2'b10: begin
                    q_nxt[DEPTH-1] = rot ? q[0] : sin_b;
                    for (int i = 0; i < DEPTH - 1; i++) q_nxt[i] = q[i+1];
                    if (!rot && !full) fill_nxt = fill + CW'(1);
                end
                2'b11: begin
                    for (int i = 0; i < DEPTH; i++) q_nxt[i] = pdata[i*WIDTH +: WIDTH];
                    fill_nxt = CW'(DEPTH);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            fill <= '0;
        end else begin
            q    <= q_nxt;
            fill <= fill_nxt;
        end
    end

    always_comb begin
        pout = '0;
        for (int i = 0; i < DEPTH; i++) pout[i*WIDTH +: WIDTH] = q[i];
    end

    // An unmatched tap_sel (DEPTH..2^CW-1) leaves tap at its zero default.
    always_comb begin
        tap = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == CW'(i)) tap = q[i];
        end
    end

endmodule

// File: tb/tb_shift_pipe_n.sv
// Purpose: self-checking bench for shift_pipe_n at WIDTH=8, DEPTH=3.
// Latency: each vector is driven at negedge and checked #1 after the following posedge.
// Backpressure: none. The scoreboard queue holds exactly one expectation per driven vector.
module tb_shift_pipe_n;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic [1:0]      mode;
    logic            rot;
    logic [W-1:0]    sin_f;
    logic [W-1:0]    sin_b;
    logic [D*W-1:0]  pdata;
    logic [CW-1:0]   tap_sel;
    logic [D*W-1:0]  pout;
    logic [W-1:0]    sout_f;
    logic [W-1:0]    sout_b;
    logic [W-1:0]    tap;
    logic [CW-1:0]   fill;
    logic            full;

    shift_pipe_n #(.WIDTH(W), .DEPTH(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .mode   (mode),
        .rot    (rot),
        .sin_f  (sin_f),
        .sin_b  (sin_b),
        .pdata  (pdata),
        .tap_sel(tap_sel),
        .pout   (pout),
        .sout_f (sout_f),
        .sout_b (sout_b),
        .tap    (tap),
        .fill   (fill),
        .full   (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           clr;
        logic [1:0]     mode;
        logic           rot;
        logic [W-1:0]   sin_f;
        logic [W-1:0]   sin_b;
        logic [D*W-1:0] pdata;
        logic [CW-1:0]  tap_sel;
        logic [D*W-1:0] exp_pout;   // {stage2, stage1, stage0}
        logic [CW-1:0]  exp_fill;
        logic [W-1:0]   exp_tap;
    } vec_t;

    typedef struct {
        logic [D*W-1:0] pout;
        logic [CW-1:0]  fill;
        logic [W-1:0]   tap;
    } exp_t;

    vec_t vecs  [17];
    vec_t stall [6];
    exp_t sb [$];

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(logic c, logic [1:0] m, logic r, logic [W-1:0] sf,
                                logic [W-1:0] sbk, logic [D*W-1:0] pd, logic [CW-1:0] ts,
                                logic [D*W-1:0] ep, logic [CW-1:0] ef, logic [W-1:0] et);
        vec_t v;
        v.clr = c; v.mode = m; v.rot = r; v.sin_f = sf; v.sin_b = sbk; v.pdata = pd;
        v.tap_sel = ts; v.exp_pout = ep; v.exp_fill = ef; v.exp_tap = et;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic apply(vec_t v);
        exp_t e;
        @(negedge clk);
        clr = v.clr; mode = v.mode; rot = v.rot; sin_f = v.sin_f; sin_b = v.sin_b;
        pdata = v.pdata; tap_sel = v.tap_sel;
        e.pout = v.exp_pout; e.fill = v.exp_fill; e.tap = v.exp_tap;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            e = sb.pop_front();
            check("pout",   32'(pout),   32'(e.pout));
            check("fill",   32'(fill),   32'(e.fill));
            check("full",   32'(full),   32'(e.fill == CW'(D)));
            check("sout_f", 32'(sout_f), 32'(e.pout[(D-1)*W +: W]));
            check("sout_b", 32'(sout_b), 32'(e.pout[W-1:0]));
            check("tap",    32'(tap),    32'(e.tap));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Forward fill, then hold
        vecs[0]  = mk(0, 2'b01, 0, 8'h11, 8'h00, 24'h0, 2'd0, 24'h000011, 2'd1, 8'h11);
        vecs[1]  = mk(0, 2'b01, 0, 8'h22, 8'h00, 24'h0, 2'd0, 24'h001122, 2'd2, 8'h22);
        vecs[2]  = mk(0, 2'b01, 0, 8'h33, 8'h00, 24'h0, 2'd2, 24'h112233, 2'd3, 8'h11);
        vecs[3]  = mk(0, 2'b01, 0, 8'h44, 8'h00, 24'h0, 2'd1, 24'h223344, 2'd3, 8'h33);
        vecs[4]  = mk(0, 2'b00, 0, 8'h99, 8'h99, 24'h0, 2'd3, 24'h223344, 2'd3, 8'h00);
        // Load {A0,B1,C2}, rotate forward twice, then rotate back twice
        vecs[5]  = mk(0, 2'b11, 1, 8'h00, 8'h00, 24'hC2B1A0, 2'd0, 24'hC2B1A0, 2'd3, 8'hA0);
        vecs[6]  = mk(0, 2'b01, 1, 8'hEE, 8'h00, 24'h0, 2'd1, 24'hB1A0C2, 2'd3, 8'hA0);
        vecs[7]  = mk(0, 2'b01, 1, 8'hEE, 8'h00, 24'h0, 2'd2, 24'hA0C2B1, 2'd3, 8'hA0);
        vecs[8]  = mk(0, 2'b10, 1, 8'h00, 8'hEE, 24'h0, 2'd0, 24'hB1A0C2, 2'd3, 8'hC2);
        vecs[9]  = mk(0, 2'b10, 1, 8'h00, 8'hEE, 24'h0, 2'd0, 24'hC2B1A0, 2'd3, 8'hA0);
        // Clear beats load on a full pipe; next hold is unchanged
        vecs[10] = mk(1, 2'b11, 0, 8'h00, 8'h00, 24'hFFFFFF, 2'd0, 24'h000000, 2'd0, 8'h00);
        vecs[11] = mk(0, 2'b00, 0, 8'h00, 8'h00, 24'h0, 2'd3, 24'h000000, 2'd0, 8'h00);
        // Backward shift and tap
        vecs[12] = mk(0, 2'b10, 0, 8'h00, 8'h5A, 24'h0, 2'd2, 24'h5A0000, 2'd1, 8'h5A);
        vecs[13] = mk(0, 2'b10, 0, 8'h00, 8'h6B, 24'h0, 2'd1, 24'h6B5A00, 2'd2, 8'h5A);
        vecs[14] = mk(0, 2'b00, 0, 8'h00, 8'h00, 24'h0, 2'd3, 24'h6B5A00, 2'd2, 8'h00);
        vecs[15] = mk(0, 2'b10, 0, 8'h00, 8'h7C, 24'h0, 2'd0, 24'h7C6B5A, 2'd3, 8'h5A);
        // Direction change with no bubble; fill saturates
        vecs[16] = mk(0, 2'b01, 0, 8'h01, 8'h00, 24'h0, 2'd1, 24'h6B5A01, 2'd3, 8'h5A);

        // Alternating shift/hold stall sequence
        stall[0] = mk(0, 2'b01, 0, 8'h01, 8'h00, 24'h0, 2'd0, 24'h000001, 2'd1, 8'h01);
        stall[1] = mk(0, 2'b00, 0, 8'hF0, 8'h00, 24'h0, 2'd0, 24'h000001, 2'd1, 8'h01);
        stall[2] = mk(0, 2'b01, 0, 8'h02, 8'h00, 24'h0, 2'd0, 24'h000102, 2'd2, 8'h02);
        stall[3] = mk(0, 2'b00, 0, 8'hF0, 8'h00, 24'h0, 2'd0, 24'h000102, 2'd2, 8'h02);
        stall[4] = mk(0, 2'b01, 0, 8'h03, 8'h00, 24'h0, 2'd0, 24'h010203, 2'd3, 8'h03);
        stall[5] = mk(0, 2'b00, 0, 8'hF0, 8'h00, 24'h0, 2'd0, 24'h010203, 2'd3, 8'h03);

        rst = 1'b1; clr = 1'b0; mode = 2'b00; rot = 1'b0;
        sin_f = '0; sin_b = '0; pdata = '0; tap_sel = '0;

        // Reset state, before any clock edge
        #2;
        check("rst_pout", 32'(pout), 32'h0);
        check("rst_fill", 32'(fill), 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_tap",  32'(tap),  32'h0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) apply(vecs[i]);

        // Asynchronous reset mid-run with nonzero contents, away from any edge
        @(negedge clk);
        mode = 2'b01; sin_f = 8'hAB; tap_sel = 2'd1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_pout",   32'(pout),   32'h0);
        check("arst_fill",   32'(fill),   32'h0);
        check("arst_full",   32'(full),   32'h0);
        check("arst_sout_f", 32'(sout_f), 32'h0);
        check("arst_tap",    32'(tap),    32'h0);
        @(posedge clk);
        #1;
        check("arst_hold_pout", 32'(pout), 32'h0);
        @(negedge clk);
        rst = 1'b0; mode = 2'b00;

        for (int i = 0; i < 6; i++) apply(stall[i]);

        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
